// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (C = control FSM, D = debug loader),
// the arbiter and the single-port data memory.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          c_req,   d_req;
  logic          c_we,    d_we;
  logic [AW-1:0] c_addr,  d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt,   d_gnt;
  logic          c_done,  d_done;
  logic [DW-1:0] c_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  // Arbiter side
  modport slave (
    input  c_req, d_req, c_we, d_we, c_addr, d_addr, c_wdata, d_wdata, mem_q,
    output c_gnt, d_gnt, c_done, d_done, c_rdata, d_rdata,
           mem_addr, mem_data, mem_rden, mem_wren
  );

  // Requester/memory side
  modport master (
    output c_req, d_req, c_we, d_we, c_addr, d_addr, c_wdata, d_wdata, mem_q,
    input  c_gnt, d_gnt, c_done, d_done, c_rdata, d_rdata,
           mem_addr, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between
// the control FSM (port C) and the debug/program loader (port D).
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t        r_state, w_state_next;
  logic          r_sel, r_last, r_we_l;
  logic [AW-1:0] r_addr_l;
  logic [DW-1:0] r_wdata_l;
  logic          r_c_done, r_d_done;
  logic [DW-1:0] r_c_rdata, r_d_rdata;

  logic          w_c_elig, w_d_elig, w_pick, w_start, w_finish;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    w_pick       = PORT_C;
    // A port whose done is pulsing is still dropping req; don't reissue it.
    w_c_elig     = io_bus.c_req & ~r_c_done;
    w_d_elig     = io_bus.d_req & ~r_d_done;
    case (r_state)
      IDLE: begin
        if (w_c_elig || w_d_elig) begin
          w_start      = 1'b1;
          w_state_next = ISSUE;
          w_pick       = (w_c_elig && w_d_elig) ? ~r_last : w_d_elig;
        end
      end
      ISSUE: begin
        if (r_we_l) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_we    = (w_pick == PORT_D) ? io_bus.d_we    : io_bus.c_we;
    w_addr  = (w_pick == PORT_D) ? io_bus.d_addr  : io_bus.c_addr;
    w_wdata = (w_pick == PORT_D) ? io_bus.d_wdata : io_bus.c_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sel     <= PORT_C;
      r_last    <= PORT_D;
      r_we_l    <= 1'b0;
      r_addr_l  <= '0;
      r_wdata_l <= '0;
      r_c_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state  <= w_state_next;
      r_c_done <= w_finish & (r_sel == PORT_C);
      r_d_done <= w_finish & (r_sel == PORT_D);
      if (w_start) begin
        r_sel     <= w_pick;
        r_last    <= w_pick;
        r_we_l    <= w_we;
        r_addr_l  <= w_addr;
        r_wdata_l <= w_wdata;
      end
      if (r_state == CAPTURE) begin
        if (r_sel == PORT_D) r_d_rdata <= io_bus.mem_q;
        else                 r_c_rdata <= io_bus.mem_q;
      end
    end
  end

  // Everything below is decoded from registers only; reset clears it at once.
  assign io_bus.c_gnt    = (r_state == ISSUE) & (r_sel == PORT_C);
  assign io_bus.d_gnt    = (r_state == ISSUE) & (r_sel == PORT_D);
  assign io_bus.mem_wren = (r_state == ISSUE) &  r_we_l;
  assign io_bus.mem_rden = (r_state == ISSUE) & ~r_we_l;
  assign io_bus.mem_addr = r_addr_l;
  assign io_bus.mem_data = r_wdata_l;
  assign io_bus.c_done   = r_c_done;
  assign io_bus.d_done   = r_d_done;
  assign io_bus.c_rdata  = r_c_rdata;
  assign io_bus.d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus
// hand-written round-robin, fairness, reset-abort and operand-latch sequences.
module tb_mem_arbiter;

  logic clock;
  logic reset;

  mem_arbiter_if #(.AW(8), .DW(8)) ifc ();

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous memory model with a backdoor preload port.
  logic [7:0] mem [256];
  logic [7:0] r_mem_q;
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clock) begin
    if (pl_en)             mem[pl_addr] <= pl_data;
    else if (ifc.mem_wren) mem[ifc.mem_addr] <= ifc.mem_data;
    if (ifc.mem_rden)      r_mem_q <= mem[ifc.mem_addr];
  end
  assign ifc.mem_q = r_mem_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic clear_reqs();
    ifc.c_req = 1'b0; ifc.c_we = 1'b0; ifc.c_addr = 8'h00; ifc.c_wdata = 8'h00;
    ifc.d_req = 1'b0; ifc.d_we = 1'b0; ifc.d_addr = 8'h00; ifc.d_wdata = 8'h00;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One isolated access on port pd (0 = C, 1 = D), checked cycle by cycle.
  task automatic run_access(input bit pd, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] rexp);
    logic [7:0] oth_rd;
    oth_rd = pd ? ifc.c_rdata : ifc.d_rdata;
    if (pd) begin
      ifc.d_req = 1'b1; ifc.d_we = we; ifc.d_addr = addr; ifc.d_wdata = wdata;
    end else begin
      ifc.c_req = 1'b1; ifc.c_we = we; ifc.c_addr = addr; ifc.c_wdata = wdata;
    end
    tick();
    chk("issue_gnt",   32'(pd ? ifc.d_gnt : ifc.c_gnt), 32'd1);
    chk("issue_ogn",   32'(pd ? ifc.c_gnt : ifc.d_gnt), 32'd0);
    chk("issue_wren",  32'(ifc.mem_wren), 32'(we));
    chk("issue_rden",  32'(ifc.mem_rden), 32'(!we));
    chk("issue_addr",  32'(ifc.mem_addr), 32'(addr));
    if (we) chk("issue_data", 32'(ifc.mem_data), 32'(wdata));
    tick();
    if (!we) begin
      chk("capture_done", 32'(pd ? ifc.d_done : ifc.c_done), 32'd0);
      chk("capture_en",   32'({ifc.mem_wren, ifc.mem_rden}), 32'd0);
      tick();
    end
    chk("done",       32'(pd ? ifc.d_done : ifc.c_done), 32'd1);
    chk("other_done", 32'(pd ? ifc.c_done : ifc.d_done), 32'd0);
    chk("gnt_off",    32'(pd ? ifc.d_gnt : ifc.c_gnt), 32'd0);
    if (!we) chk("rdata", 32'(pd ? ifc.d_rdata : ifc.c_rdata), 32'(rexp));
    chk("other_rdata_hold", 32'(pd ? ifc.c_rdata : ifc.d_rdata), 32'(oth_rd));
    if (pd) ifc.d_req = 1'b0; else ifc.c_req = 1'b0;
    tick();
    chk("done_pulse", 32'(pd ? ifc.d_done : ifc.c_done), 32'd0);
    $display("txn port=%s %s addr=0x%02h wdata=0x%02h rdata=0x%02h",
             pd ? "D" : "C", we ? "WR" : "RD", addr, wdata,
             pd ? ifc.d_rdata : ifc.c_rdata);
  endtask

  typedef struct {
    bit         pd;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ng;
    int k;
    vecs[0] = '{pd: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, rexp: 8'h5A};
    vecs[1] = '{pd: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h3C, rexp: 8'h00};
    vecs[2] = '{pd: 1'b0, we: 1'b0, addr: 8'h20, wdata: 8'h00, rexp: 8'h3C};
    vecs[3] = '{pd: 1'b1, we: 1'b0, addr: 8'h10, wdata: 8'h00, rexp: 8'h5A};
    vecs[4] = '{pd: 1'b0, we: 1'b1, addr: 8'hFF, wdata: 8'h81, rexp: 8'h00};
    vecs[5] = '{pd: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, rexp: 8'h81};
    vecs[6] = '{pd: 1'b1, we: 1'b1, addr: 8'h00, wdata: 8'hC3, rexp: 8'h00};
    vecs[7] = '{pd: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, rexp: 8'hC3};

    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    clear_reqs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gnt",   32'({ifc.c_gnt, ifc.d_gnt}), 32'd0);
    chk("rst_done",  32'({ifc.c_done, ifc.d_done}), 32'd0);
    chk("rst_en",    32'({ifc.mem_wren, ifc.mem_rden}), 32'd0);
    chk("rst_addr",  32'(ifc.mem_addr), 32'd0);
    chk("rst_data",  32'(ifc.mem_data), 32'd0);
    chk("rst_rdata", 32'({ifc.c_rdata, ifc.d_rdata}), 32'd0);

    preload(8'h10, 8'h5A);
    preload(8'h05, 8'h11);
    preload(8'h06, 8'h22);
    preload(8'h01, 8'h0A);
    preload(8'h02, 8'h0B);
    preload(8'h40, 8'h44);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_access(vecs[i].pd, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rexp);

    // Both ports stream reads from reset: grants must alternate C, D, C, D...
    do_reset();
    ifc.c_req = 1'b1; ifc.c_we = 1'b0; ifc.c_addr = 8'h01;
    ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 8'h02;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
      tick();
      if (ifc.c_done) chk("rr_c_rdata", 32'(ifc.c_rdata), 32'h0A);
      if (ifc.d_done) chk("rr_d_rdata", 32'(ifc.d_rdata), 32'h0B);
      if (ifc.c_gnt || ifc.d_gnt) begin
        chk($sformatf("rr_grant%0d", ng), 32'({ifc.c_gnt, ifc.d_gnt}),
            (ng % 2 == 0) ? 32'd2 : 32'd1);
        if (ng == 1) chk("rr_first_d_cycle", 32'(cyc + 1), 32'd4);
        $display("txn rr grant %0d to %s at cycle %0d", ng, ifc.d_gnt ? "D" : "C", cyc + 1);
        ng++;
        if (ng == 8) ifc.c_req = 1'b0;
      end
    end
    chk("rr_grant_count", 32'(ng), 32'd8);
    k = 0;
    while (!ifc.d_done && k < 6) begin tick(); k++; end
    chk("rr_last_done", 32'(ifc.d_done), 32'd1);
    ifc.d_req = 1'b0;
    tick();
    tick();

    // C keeps requesting; D joins in a tie right after C's access and must win it.
    do_reset();
    ifc.c_req = 1'b1; ifc.c_we = 1'b0; ifc.c_addr = 8'h05;
    ifc.d_we = 1'b1; ifc.d_addr = 8'h50; ifc.d_wdata = 8'h99;
    tick();
    chk("fair_c_gnt1", 32'(ifc.c_gnt), 32'd1);
    tick();
    tick();
    chk("fair_c_done1", 32'(ifc.c_done), 32'd1);
    tick();
    ifc.d_req = 1'b1;
    tick();
    chk("fair_d_gnt", 32'({ifc.c_gnt, ifc.d_gnt}), 32'd1);
    tick();
    chk("fair_d_done", 32'(ifc.d_done), 32'd1);
    ifc.d_req = 1'b0;
    tick();
    chk("fair_c_gnt2", 32'({ifc.c_gnt, ifc.d_gnt}), 32'd2);
    tick();
    tick();
    chk("fair_c_done2", 32'(ifc.c_done), 32'd1);
    ifc.c_req = 1'b0;
    tick();
    $display("txn fairness sequence C, D, C");
    run_access(1'b1, 1'b0, 8'h50, 8'h00, 8'h99);

    // Reset during the ISSUE cycle of a C write aborts it without a done.
    do_reset();
    ifc.c_req = 1'b1; ifc.c_we = 1'b1; ifc.c_addr = 8'h30; ifc.c_wdata = 8'h77;
    tick();
    chk("abort_pre_wren", 32'(ifc.mem_wren), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_wren", 32'(ifc.mem_wren), 32'd0);
    chk("abort_gnt",  32'(ifc.c_gnt), 32'd0);
    clear_reqs();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(ifc.c_done), 32'd0);
    end
    $display("txn reset abort of C write 0x30");
    run_access(1'b0, 1'b0, 8'h40, 8'h00, 8'h44);

    // Address changed during ISSUE must not affect the latched access.
    ifc.c_req = 1'b1; ifc.c_we = 1'b0; ifc.c_addr = 8'h05;
    tick();
    ifc.c_addr = 8'h06;
    #1;
    chk("latch_addr_issue", 32'(ifc.mem_addr), 32'h05);
    tick();
    chk("latch_addr_capture", 32'(ifc.mem_addr), 32'h05);
    tick();
    chk("latch_done",  32'(ifc.c_done), 32'd1);
    chk("latch_rdata", 32'(ifc.c_rdata), 32'h11);
    ifc.c_req = 1'b0;
    tick();
    $display("txn latched read addr 0x05 rdata=0x%02h", ifc.c_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
